counter_channel: RTL and testbench

COUNTER_CHANNEL -- requirements
Module: counter_channel

---
 rtl/counter_channel.sv | 209 ++++++++++++++++++++
 tb/tb_counter_channel.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/counter_channel.sv
// ---------------------------------------------------------------------------
// counter_channel
// One channel of an 8254-style programmable interval timer. Supports mode 0
// (interrupt on terminal count) and mode 2 (rate generator), binary counting,
// counter latch commands and LSB/MSB/two-byte access through an 8-bit bus.
//
// Ports
//   CLK          : single clock, also the count clock (rising edge)
//   RST          : asynchronous, active-high reset
//   DataIn[7:0]  : bus byte for control words and count bytes
//   WriteCounter : level strobe, write this channel's count register
//   WriteControl : level strobe, write the shared control register
//   ReadCounter  : level strobe, read this channel
//   GATE         : count enable
//   DataOut[7:0] : registered read byte
//   OUT          : registered counter output
// Every strobe acts once, on its 0->1 transition as seen at CLK.
// ---------------------------------------------------------------------------
module counter_channel #(
    parameter logic [1:0] COUNTER_ID = 2'd0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] DataIn,
    input  logic       WriteCounter,
    input  logic       WriteControl,
    input  logic       ReadCounter,
    input  logic       GATE,
    output logic [7:0] DataOut,
    output logic       OUT
);

    typedef enum logic {
        MODE0 = 1'b0,
        MODE2 = 1'b1
    } mode_t;

    // Edge detectors
    logic        r_wcnt_d;
    logic        r_wctl_d;
    logic        r_rd_d;
    logic        r_gate_d;

    // Programming state
    mode_t       r_mode;
    logic [1:0]  r_rw;
    logic        r_cfg;          // a matching control word has been seen
    logic        r_wr_msb;       // next count write byte is the MSB
    logic        r_rd_msb;       // next read byte is the MSB
    logic [7:0]  r_lsb_tmp;      // first byte of a two-byte write
    logic [15:0] r_count_reg;    // last complete count written

    // Counting state
    logic [15:0] r_ce;           // count element (live count)
    logic        r_load_pending; // copy count register into CE next edge
    logic        r_counting;
    logic [15:0] r_latch;
    logic        r_latched;
    logic        r_out;
    logic [7:0]  r_dout;

    logic        w_ctl_ev;
    logic        w_cnt_ev;
    logic        w_rd_ev;
    logic        w_sc_match;
    logic [15:0] w_rd_src;
    logic        w_unused_bits;

    assign w_ctl_ev   = WriteControl & ~r_wctl_d;
    assign w_cnt_ev   = WriteCounter & ~r_wcnt_d;
    assign w_rd_ev    = ReadCounter  & ~r_rd_d;
    assign w_sc_match = (DataIn[7:6] == COUNTER_ID);
    assign w_rd_src   = r_latched ? r_latch : r_ce;

    // Mode code bit 3 is a don't-care and BCD counting is not supported.
    assign w_unused_bits = &{1'b0, DataIn[3], DataIn[0]};

    // NOTE: every register below uses non-blocking assignments; later
    // assignments in the same block deliberately override earlier ones, which
    // is how bus writes take precedence over the counting engine.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wcnt_d       <= 1'b0;
            r_wctl_d       <= 1'b0;
            r_rd_d         <= 1'b0;
            r_gate_d       <= 1'b0;
            r_mode         <= MODE0;
            r_rw           <= 2'b11;
            r_cfg          <= 1'b0;
            r_wr_msb       <= 1'b0;
            r_rd_msb       <= 1'b0;
            r_lsb_tmp      <= 8'h00;
            r_count_reg    <= 16'h0000;
            r_ce           <= 16'h0000;
            r_load_pending <= 1'b0;
            r_counting     <= 1'b0;
            r_latch        <= 16'h0000;
            r_latched      <= 1'b0;
            r_out          <= 1'b0;
            r_dout         <= 8'h00;
        end else begin
            r_wcnt_d <= WriteCounter;
            r_wctl_d <= WriteControl;
            r_rd_d   <= ReadCounter;
            r_gate_d <= GATE;

            // ---------------- counting engine ----------------
            if (r_load_pending) begin
                r_ce           <= r_count_reg;
                r_load_pending <= 1'b0;
                r_counting     <= 1'b1;
                if (r_mode == MODE2)
                    r_out <= 1'b1;
            end else if (r_counting) begin
                if (r_mode == MODE0) begin
                    if (GATE) begin
                        // 0000 wraps to FFFF, so a zero count means 65536.
                        r_ce <= r_ce - 16'd1;
                        if (r_ce == 16'd1)
                            r_out <= 1'b1;
                    end
                end else begin
                    if (!GATE) begin
                        r_out <= 1'b1;
                    end else if (!r_gate_d) begin
                        // Gate re-opened: restart the period.
                        r_ce  <= r_count_reg;
                        r_out <= 1'b1;
                    end else if (r_ce == 16'd1) begin
                        r_ce  <= r_count_reg;
                        r_out <= 1'b1;
                    end else begin
                        r_ce <= r_ce - 16'd1;
                        // OUT goes low for the single clock spent at count 1.
                        if (r_ce == 16'd2)
                            r_out <= 1'b0;
                    end
                end
            end

            // ---------------- bus side ----------------
            if (w_ctl_ev) begin
                if (w_sc_match) begin
                    if (DataIn[5:4] == 2'b00) begin
                        if (!r_latched) begin
                            r_latch   <= r_ce;
                            r_latched <= 1'b1;
                        end
                    end else begin
                        r_rw           <= DataIn[5:4];
                        r_mode         <= (DataIn[2:1] == 2'b10) ? MODE2 : MODE0;
                        r_out          <= (DataIn[2:1] == 2'b10);
                        r_counting     <= 1'b0;
                        r_load_pending <= 1'b0;
                        r_wr_msb       <= 1'b0;
                        r_rd_msb       <= 1'b0;
                        r_cfg          <= 1'b1;
                    end
                end
            end else if (w_cnt_ev && r_cfg) begin
                if (r_mode == MODE0)
                    r_out <= 1'b0;
                if (r_rw == 2'b11 && !r_wr_msb) begin
                    r_lsb_tmp <= DataIn;
                    r_wr_msb  <= 1'b1;
                    if (r_mode == MODE0) begin
                        r_counting     <= 1'b0;
                        r_load_pending <= 1'b0;
                    end
                end else begin
                    case (r_rw)
                        2'b01:   r_count_reg <= {8'h00, DataIn};
                        2'b10:   r_count_reg <= {DataIn, 8'h00};
                        default: r_count_reg <= {DataIn, r_lsb_tmp};
                    endcase
                    r_wr_msb <= 1'b0;
                    // A running mode 2 counter picks up the new value at its
                    // next reload instead of restarting now.
                    if (r_mode == MODE0 || !r_counting)
                        r_load_pending <= 1'b1;
                end
            end else if (w_rd_ev) begin
                case (r_rw)
                    2'b10: begin
                        r_dout    <= w_rd_src[15:8];
                        r_latched <= 1'b0;
                    end
                    2'b11: begin
                        if (r_rd_msb) begin
                            r_dout    <= w_rd_src[15:8];
                            r_latched <= 1'b0;
                        end else begin
                            r_dout <= w_rd_src[7:0];
                        end
                        r_rd_msb <= ~r_rd_msb;
                    end
                    default: begin
                        r_dout    <= w_rd_src[7:0];
                        r_latched <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign OUT     = r_out;
    assign DataOut = r_dout;

endmodule

// File: tb/tb_counter_channel.sv
// ---------------------------------------------------------------------------
// tb_counter_channel
// Directed testbench for counter_channel (COUNTER_ID = 0). Inputs change 1 ns
// after a rising edge and outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_counter_channel;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] DataIn = 8'h00;
    logic       WriteCounter = 1'b0;
    logic       WriteControl = 1'b0;
    logic       ReadCounter = 1'b0;
    logic       GATE = 1'b1;
    logic [7:0] DataOut;
    logic       OUT;

    int n_cmp = 0;
    int n_err = 0;

    counter_channel #(.COUNTER_ID(2'd0)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .DataIn       (DataIn),
        .WriteCounter (WriteCounter),
        .WriteControl (WriteControl),
        .ReadCounter  (ReadCounter),
        .GATE         (GATE),
        .DataOut      (DataOut),
        .OUT          (OUT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Each strobe is raised for exactly one edge (the event edge); callers
    // leave at least one edge between two pulses of the same strobe.
    task automatic wr_ctl(input logic [7:0] b);
        DataIn = b;
        WriteControl = 1'b1;
        tick();
        WriteControl = 1'b0;
    endtask

    task automatic wr_cnt(input logic [7:0] b);
        DataIn = b;
        WriteCounter = 1'b1;
        tick();
        WriteCounter = 1'b0;
    endtask

    task automatic wr_cnt2(input logic [7:0] lsb, input logic [7:0] msb);
        wr_cnt(lsb);
        tick();
        wr_cnt(msb);
    endtask

    task automatic rd();
        ReadCounter = 1'b1;
        tick();
        ReadCounter = 1'b0;
    endtask

    // Edges until OUT is seen high, bounded; returns bound+1 on timeout.
    task automatic edges_to_out_high(input int bound, output int n);
        n = bound + 1;
        for (int k = 1; k <= bound; k++) begin
            tick();
            if (OUT === 1'b1) begin
                n = k;
                break;
            end
        end
    endtask

    initial begin
        int n;

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_out", 32'(OUT), 32'd0);
        check("rst_dout", 32'(DataOut), 32'h00);
        RST = 1'b0;
        tick();

        // ---------------- mode 0, RW=11, count 0005 ----------------
        wr_ctl(8'h30);
        check("m0_ctl_out", 32'(OUT), 32'd0);
        wr_cnt2(8'h05, 8'h00);                 // MSB edge = N
        for (int k = 1; k <= 5; k++) begin
            tick();
            check($sformatf("m0_low_%0d", k), 32'(OUT), 32'd0);
        end
        tick();                                // N+6
        check("m0_high_n6", 32'(OUT), 32'd1);

        // ---------------- latch at 1234, reads ----------------
        wr_ctl(8'h30);
        wr_cnt2(8'h40, 8'h12);                 // N; CE = 1240 after N+1
        for (int k = 1; k <= 13; k++) tick();
        wr_ctl(8'h00);                         // latch at N+14 -> 1234
        rd();                                  // N+15
        check("latch_lsb", 32'(DataOut), 32'h34);
        tick();
        rd();                                  // N+17
        check("latch_msb", 32'(DataOut), 32'h12);
        tick();
        rd();                                  // N+19, live 122F
        check("live_lsb", 32'(DataOut), 32'h2F);
        tick();

        // ---------------- foreign control word ignored ----------------
        wr_ctl(8'h54);                         // SC=1, N+21
        check("foreign_out", 32'(OUT), 32'd0);
        rd();                                  // N+22, live 122C, MSB turn
        check("foreign_msb", 32'(DataOut), 32'h12);
        tick();
        rd();                                  // N+24, live 122A
        check("foreign_lsb", 32'(DataOut), 32'h2A);
        tick();

        // ---------------- mode 2, RW=01, count 04 ----------------
        wr_ctl(8'h14);
        check("m2_ctl_out", 32'(OUT), 32'd1);
        wr_cnt(8'h04);                         // N
        for (int k = 1; k <= 12; k++) begin
            tick();
            check($sformatf("m2_out_%0d", k), 32'(OUT), (k % 4 == 0) ? 32'd0 : 32'd1);
        end
        GATE = 1'b0;                           // count is 1 here
        tick();                                // N+13
        check("m2_gate0_a", 32'(OUT), 32'd1);
        rd();                                  // N+14
        check("m2_gate0_b", 32'(OUT), 32'd1);
        check("m2_frozen", 32'(DataOut), 32'h01);
        tick();                                // N+15
        check("m2_gate0_c", 32'(OUT), 32'd1);
        GATE = 1'b1;
        for (int k = 16; k <= 19; k++) begin
            tick();
            check($sformatf("m2_regate_%0d", k), 32'(OUT), (k == 19) ? 32'd0 : 32'd1);
        end

        // ---------------- mode 0, RW=10, count 0100 ----------------
        wr_ctl(8'h20);
        wr_cnt(8'h01);
        edges_to_out_high(400, n);
        check("m0_rw10_edges", 32'(n), 32'd257);

        // ---------------- mode 0, count 0000 = 65536 ----------------
        wr_ctl(8'h30);
        wr_cnt2(8'h00, 8'h00);
        check("m0_zero_start", 32'(OUT), 32'd0);
        edges_to_out_high(70000, n);
        check("m0_zero_edges", 32'(n), 32'd65537);

        // ---------------- reset mid two-byte write ----------------
        wr_ctl(8'h34);                         // mode 2, RW=11
        check("pre_rst_out", 32'(OUT), 32'd1);
        wr_cnt(8'h05);
        tick();
        RST = 1'b1;
        #1;
        check("rst_mid_out", 32'(OUT), 32'd0);
        check("rst_mid_dout", 32'(DataOut), 32'h00);
        tick();
        RST = 1'b0;
        tick();
        wr_cnt(8'h03);
        for (int k = 1; k <= 10; k++) tick();
        check("post_rst_idle", 32'(OUT), 32'd0);
        rd();
        check("post_rst_cnt", 32'(DataOut), 32'h00);
        tick();
        wr_ctl(8'h30);
        wr_cnt2(8'h03, 8'h00);                 // N, count 0003
        tick();
        tick();
        tick();
        check("post_rst_n3", 32'(OUT), 32'd0);
        tick();
        check("post_rst_n4", 32'(OUT), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
